// File: rtl/uart_tx_fifo_if.sv
// Host and transmitter handshake bundle for uart_tx_fifo.
//   slave  : the FIFO side (takes host writes and tx status, drives flags/launch)
//   master : the host + transmitter side
// Host signals: wr_en, wr_data -> ; <- full, empty, count, overflow (, afull)
// Transmitter signals: <- tx_start, din ; -> tx_idle, tx_done
// afull is present only when UART_TX_FIFO_AFULL_EN is defined.
interface uart_tx_fifo_if #(
  parameter int unsigned DBITS  = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [DBITS-1:0]  wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
`ifdef UART_TX_FIFO_AFULL_EN
  logic              afull;
`endif
  logic              tx_start;
  logic [DBITS-1:0]  din;
  logic              tx_idle;
  logic              tx_done;

`ifdef UART_TX_FIFO_AFULL_EN
  modport slave (
    input  wr_en, wr_data, tx_idle, tx_done,
    output full, empty, count, overflow, afull, tx_start, din
  );
  modport master (
    output wr_en, wr_data, tx_idle, tx_done,
    input  full, empty, count, overflow, afull, tx_start, din
  );
`else
  modport slave (
    input  wr_en, wr_data, tx_idle, tx_done,
    output full, empty, count, overflow, tx_start, din
  );
  modport master (
    output wr_en, wr_data, tx_idle, tx_done,
    input  full, empty, count, overflow, tx_start, din
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO in front of a UART transmitter plus the launch FSM that
// feeds it one byte at a time over the tx_start/din/tx_idle/tx_done handshake.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset (shared with the transmitter)
//   bus  : uart_tx_fifo_if.slave (host write side + transmitter launch side)
// Optional feature: define UART_TX_FIFO_AFULL_EN to add parameter AFULL_LVL
// and the afull flag (count >= AFULL_LVL).
module uart_tx_fifo #(
  parameter int unsigned DBITS     = 8,
  parameter int unsigned ADDR_W    = 4
`ifdef UART_TX_FIFO_AFULL_EN
  , parameter int unsigned AFULL_LVL = 12
`endif
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2
  } state_e;

  logic [DBITS-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q;
  state_e            state_q;
  logic              tx_start_q;
  logic [DBITS-1:0]  din_q;

  logic full_w, empty_w, accept_w, pop_w;

  // Flags decoded straight from the occupancy register
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  assign accept_w = bus.wr_en && !full_w;
  assign pop_w    = (state_q == S_IDLE) && !empty_w && bus.tx_idle;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept_w) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_w)    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    unique case ({accept_w, pop_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are meaningless once pointers are reset
  always_ff @(posedge clk) begin
    if (accept_w) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // Pointer, occupancy and overflow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= bus.wr_en && full_w;
    end
  end

  // Launch FSM: pop at launch, hold tx_start one cycle, then wait for tx_done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      din_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop_w) begin
            tx_start_q <= 1'b1;
            din_q      <= mem_q[rd_ptr_q];
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tx_start_q <= 1'b0;
          state_q    <= S_BUSY;
        end
        S_BUSY: begin
          if (bus.tx_done) state_q <= S_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_start = tx_start_q;
  assign bus.din      = din_q;

`ifdef UART_TX_FIFO_AFULL_EN
  assign bus.afull = (count_q >= CNT_W'(AFULL_LVL));
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural serial transmitter.
module tb_uart_tx_fifo;
  localparam int unsigned DBITS  = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DBITS(DBITS), .ADDR_W(ADDR_W)) bus ();
  uart_tx_fifo #(.DBITS(DBITS), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: captures din on tx_start, shifts 8 bits LSB-first,
  // pulses tx_done, and raises tx_idle on the edge tx_done falls.
  logic       hold_idle = 1'b0;
  logic       m_idle;
  int         m_phase;
  int         m_bit;
  logic [7:0] m_sh, m_rx;
  int         cyc = 0;
  int         last_done = -1000;
  logic [7:0] rx_q[$];
  int         gap_q[$];
  int         n_start = 0;
  logic       prev_start = 1'b0;

  assign bus.tx_idle = m_idle && !hold_idle;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idle      <= 1'b1;
      bus.tx_done <= 1'b0;
      m_phase     <= 0;
      m_bit       <= 0;
      m_sh        <= '0;
      m_rx        <= '0;
    end else begin
      cyc         <= cyc + 1;
      bus.tx_done <= 1'b0;
      if (bus.tx_done) last_done <= cyc;
      case (m_phase)
        0: if (bus.tx_start) begin
          m_sh    <= bus.din;
          m_idle  <= 1'b0;
          m_bit   <= 0;
          m_phase <= 1;
          gap_q.push_back(cyc - last_done);
        end
        1: begin
          m_rx  <= {m_sh[m_bit], m_rx[7:1]};
          m_bit <= m_bit + 1;
          if (m_bit == 7) begin
            rx_q.push_back({m_sh[m_bit], m_rx[7:1]});
            bus.tx_done <= 1'b1;
            m_phase     <= 2;
          end
        end
        default: begin
          m_idle  <= 1'b1;
          m_phase <= 0;
        end
      endcase
    end
  end

  // Launch pulses: single-cycle, and only into an idle transmitter
  always @(posedge clk) begin
    if (rst && bus.tx_start) begin
      n_start++;
      check("start_one_cycle", 32'(prev_start), 32'd0);
      check("start_tx_ready", 32'(m_phase), 32'd0);
    end
    prev_start <= bus.tx_start;
  end

  logic [7:0] exp_q[$];
  int rx_idx = 0;

  task automatic wr_cycle(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.wr_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for every expected byte, then compare in order
  task automatic drain();
    int need;
    int n;
    bus.wr_en = 1'b0;
    need = rx_idx + exp_q.size();
    n = 0;
    while (rx_q.size() < need && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (16) @(posedge clk);
    #1;
    check("drain_count", 32'(rx_q.size() - rx_idx), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (rx_idx < rx_q.size()) check("drain_data", 32'(rx_q[rx_idx]), 32'(exp_q[i]));
      rx_idx++;
    end
    rx_idx = rx_q.size();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, g0, sent, chunk, d;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_din", 32'(bus.din), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
`ifdef UART_TX_FIFO_AFULL_EN
    check("rst_afull", 32'(bus.afull), 32'd0);
`endif
    rst = 1'b1;
    idle_cycles(2);

    // Single byte: launch latency and LSB-first delivery
    wr_cycle(8'hA5);
    bus.wr_en = 1'b0;
    check("sb_empty_E", 32'(bus.empty), 32'd0);
    check("sb_count_E", 32'(bus.count), 32'd1);
    check("sb_start_E", 32'(bus.tx_start), 32'd0);
    @(posedge clk); #1;
    check("sb_start_E1", 32'(bus.tx_start), 32'd1);
    check("sb_din_E1", 32'(bus.din), 32'hA5);
    check("sb_count_E1", 32'(bus.count), 32'd0);
    @(posedge clk); #1;
    check("sb_start_E2", 32'(bus.tx_start), 32'd0);
    check("sb_din_hold", 32'(bus.din), 32'hA5);
    exp_q.push_back(8'hA5);
    drain();

    // Burst 01..05: order, pulse count, 2-cycle relaunch after tx_done
    n0 = n_start;
    g0 = gap_q.size();
    for (int i = 1; i <= 5; i++) begin
      wr_cycle(8'(i));
      exp_q.push_back(8'(i));
    end
    drain();
    check("burst_starts", 32'(n_start - n0), 32'd5);
    for (int k = 1; k <= 4; k++)
      if (g0 + k < gap_q.size()) check("burst_gap", 32'(gap_q[g0 + k]), 32'd2);

    // Full / overflow with the transmitter held busy
    hold_idle = 1'b1;
    idle_cycles(3);
    for (int i = 0; i < 19; i++) begin
      d = int'($urandom_range(255));
      wr_cycle(8'(d));
      if (i < DEPTH) exp_q.push_back(8'(d));
      check("fo_count", 32'(bus.count), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
      check("fo_full", 32'(bus.full), 32'(i >= DEPTH - 1));
      check("fo_overflow", 32'(bus.overflow), 32'(i >= DEPTH));
    end
    idle_cycles(1);
    check("fo_overflow_end", 32'(bus.overflow), 32'd0);
    check("fo_count_end", 32'(bus.count), 32'(DEPTH));
    hold_idle = 1'b0;
    drain();

    // Accept and pop on the same edge keeps the count
    hold_idle = 1'b1;
    idle_cycles(2);
    for (int i = 0; i < 3; i++) begin
      d = int'($urandom_range(255));
      wr_cycle(8'(d));
      exp_q.push_back(8'(d));
    end
    check("sim_count_pre", 32'(bus.count), 32'd3);
    d = int'($urandom_range(255));
    hold_idle = 1'b0;
    wr_cycle(8'(d));
    exp_q.push_back(8'(d));
    bus.wr_en = 1'b0;
    check("sim_count", 32'(bus.count), 32'd3);
    check("sim_start", 32'(bus.tx_start), 32'd1);
    drain();

    // Wrap: 40 random bytes in random chunks with random spacing
    sent = 0;
    while (sent < 40) begin
      chunk = int'($urandom_range(12, 1));
      if (sent + chunk > 40) chunk = 40 - sent;
      for (int i = 0; i < chunk; i++) begin
        d = int'($urandom_range(255));
        wr_cycle(8'(d));
        exp_q.push_back(8'(d));
        idle_cycles(int'($urandom_range(2)));
      end
      sent += chunk;
      drain();
    end

    // Reset mid-frame with 5 queued
    for (int i = 0; i < 6; i++) wr_cycle(8'(8'h30 + i));
    bus.wr_en = 1'b0;
    check("mr_count_pre", 32'(bus.count), 32'd5);
    rst = 1'b0;
    #1;
    check("mr_count", 32'(bus.count), 32'd0);
    check("mr_empty", 32'(bus.empty), 32'd1);
    check("mr_tx_start", 32'(bus.tx_start), 32'd0);
    check("mr_din", 32'(bus.din), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    rx_idx = rx_q.size();
    n0 = n_start;
    idle_cycles(20);
    check("mr_no_launch", 32'(n_start - n0), 32'd0);
    check("mr_still_empty", 32'(bus.empty), 32'd1);
    wr_cycle(8'h5A);
    exp_q.push_back(8'h5A);
    drain();

`ifdef UART_TX_FIFO_AFULL_EN
    // Almost-full threshold at 12
    hold_idle = 1'b1;
    idle_cycles(2);
    for (int i = 1; i <= 12; i++) begin
      d = int'($urandom_range(255));
      wr_cycle(8'(d));
      exp_q.push_back(8'(d));
      if (i == 11) begin
        check("af_count11", 32'(bus.count), 32'd11);
        check("af_afull11", 32'(bus.afull), 32'd0);
      end
    end
    check("af_count12", 32'(bus.count), 32'd12);
    check("af_afull12", 32'(bus.afull), 32'd1);
    hold_idle = 1'b0;
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
